// File: rtl/led_shining.sv
// Two-LED heartbeat: a prescaler produces a one-cycle tick every CNT_1S+1 clocks,
// and {led2, led1} steps through a 2-bit binary count on each tick.
module led_shining #(
    parameter logic [31:0] CNT_1S = 32'd49_999_999
) (
    input  logic clk,
    input  logic rst_n,
    output logic led1,
    output logic led2
);

    // Counter just wide enough to hold CNT_1S; never narrower than one bit.
    localparam int W = (CNT_1S < 32'd2) ? 1 : $clog2({1'b0, CNT_1S} + 33'd1);
    localparam logic [W-1:0] CNT_MAX = CNT_1S[W-1:0];

    logic [W-1:0] cnt;
    logic         tick;
    logic         half;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            half <= 1'b0;
            led1 <= 1'b0;
            led2 <= 1'b0;
        end else begin
            if (tick) begin
                cnt  <= '0;
                half <= ~half;
                led1 <= ~led1;
                // led2 toggles on the second tick of each pair, carrying out of led1.
                if (half) begin
                    led2 <= ~led2;
                end
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_shining.sv
// Directed bench for led_shining with CNT_1S=19: reset values, tick cadence,
// the 00->01->10->11 LED sequence, async reset with clock stopped, and mid-period reset.
module tb_led_shining;

    localparam int CNT = 19;
    localparam int PER = CNT + 1;

    logic clk;
    logic clk_en;
    logic rst_n;
    logic led1;
    logic led2;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_seen;

    logic [1:0] exp_q[$];

    led_shining #(.CNT_1S(32'd19)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .led1 (led1),
        .led2 (led2)
    );

    // Clock/reset: 10 ns period, gateable so reset can be exercised with no clock.
    initial begin
        clk    = 1'b0;
        clk_en = 1'b1;
        rst_n  = 1'b0;
    end

    always #5 clk = clk_en ? ~clk : 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected {led2,led1} after edge k following a reset release.
    function automatic logic [1:0] led_model(input int k);
        logic [1:0] v;
        v = 2'((k / PER) % 4);
        return v;
    endfunction

    // Advance n edges (numbered from 'first'), checking LEDs, prescaler and tick.
    task automatic run_edges(input int first, input int n);
        logic [1:0] exp_led;
        for (int k = first; k < first + n; k++) begin
            exp_q.push_back(led_model(k));
            @(posedge clk);
            #1;
            exp_led = exp_q.pop_front();
            check($sformatf("led@%0d", k), {30'd0, led2, led1}, {30'd0, exp_led});
            check($sformatf("cnt@%0d", k), 32'(dut.cnt), 32'(k % PER));
            check($sformatf("cnt_bound@%0d", k), {31'd0, (32'(dut.cnt) <= CNT)}, 32'd1);
            check($sformatf("tick@%0d", k), {31'd0, dut.tick}, {31'd0, (k % PER) == CNT});
            if (dut.tick) tick_seen++;
        end
    endtask

    initial begin
        int edges_to_rise;

        // Reset held 0-20 ns: outputs low while clock runs.
        #12;
        check("reset_led", {30'd0, led2, led1}, 32'd0);
        check("reset_cnt", 32'(dut.cnt), 32'd0);
        #8;
        rst_n = 1'b1;

        // Steady state over 200 edges: covers first tick, 01/10/11/00 sequence,
        // simultaneous toggles at edges 40 and 80.
        tick_seen = 0;
        run_edges(1, 200);
        check("tick_count_200", 32'(tick_seen), 32'd10);

        // Async reset with clock stopped: 3 ns pulse.
        clk_en = 1'b0;
        #20;
        check("pre_pulse_led", {30'd0, led2, led1}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("pulse_led", {30'd0, led2, led1}, 32'd0);
        check("pulse_cnt", 32'(dut.cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        #5;
        clk_en = 1'b1;

        // Run to edge 50 (cnt=10, led2=1, led1=0), then reset mid-period.
        run_edges(1, 50);
        rst_n = 1'b0;
        #1;
        check("mid_reset_led", {30'd0, led2, led1}, 32'd0);
        check("mid_reset_cnt", 32'(dut.cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_reset_hold_led", {30'd0, led2, led1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // led1 must rise exactly PER edges after release; bounded wait.
        edges_to_rise = 0;
        for (int i = 1; i <= 2 * PER; i++) begin
            @(posedge clk);
            #1;
            if (led1 === 1'b1) begin
                edges_to_rise = i;
                break;
            end
        end
        check("mid_reset_first_rise", 32'(edges_to_rise), 32'(PER));
        check("mid_reset_led2", {31'd0, led2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
